// File: rtl/game_sequencer.sv
// Purpose : runner-game sequencer: start/run/die/game-over flow, score, speed, palette control.
// Latency : all outputs registered one cycle after the triggering input, except o_speed (combinational from score).
// Backpressure: none; every tick and press is consumed in the cycle it arrives or deliberately ignored.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   i_tick_60hz         - frame-start pulse; paces the death flash and game-over lockout
//   i_tick_20hz         - score tick pulse (coincides with every third 60 Hz tick)
//   i_collision         - sticky collision level from graphics, cleared by o_game_start_pulse
//   i_button            - synchronized jump/start button level
//   o_game_start_pulse  - one-cycle start/restart pulse
//   o_state             - IDLE=0, RUNNING=1, DYING=2, GAME_OVER=3
//   o_score             - binary score, saturating at 999
//   o_speed             - obstacle speed level derived from score
//   o_rgb_scheme        - day/night scheme, flips at each hundred points
//   o_invert            - palette invert used for the death flash
module game_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick_60hz,
  input  logic       i_tick_20hz,
  input  logic       i_collision,
  input  logic       i_button,
  output logic       o_game_start_pulse,
  output logic [1:0] o_state,
  output logic [9:0] o_score,
  output logic [1:0] o_speed,
  output logic       o_rgb_scheme,
  output logic       o_invert
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUNNING   = 2'd1,
    S_DYING     = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  localparam logic [9:0] SCORE_MAX     = 10'd999;
  localparam logic [5:0] DYING_TICKS   = 6'd48;
  localparam logic [5:0] LOCKOUT_TICKS = 6'd30;

  state_t     state_q, state_d;
  logic [9:0] score_q, score_d;
  logic       rgb_q, rgb_d;
  logic       inv_q, inv_d;
  logic       start_q, start_d;
  logic [5:0] frame_q, frame_d;
  logic       btn_q;
  // Delayed copy of the start pulse: together with start_q it covers the two
  // cycles in which the collision flag may still hold the previous game's value.
  logic       mask_q;

  logic       press;
  logic       coll_masked;
  logic [9:0] score_inc;
  logic [5:0] frame_inc;

  function automatic logic is_hundred(input logic [9:0] v);
    case (v)
      10'd100, 10'd200, 10'd300, 10'd400, 10'd500,
      10'd600, 10'd700, 10'd800, 10'd900: is_hundred = 1'b1;
      default:                            is_hundred = 1'b0;
    endcase
  endfunction

  assign press       = i_button & ~btn_q;
  assign coll_masked = start_q | mask_q;
  assign score_inc   = score_q + 10'd1;
  assign frame_inc   = frame_q + 6'd1;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    rgb_d   = rgb_q;
    inv_d   = inv_q;
    start_d = 1'b0;
    frame_d = frame_q;

    case (state_q)
      S_IDLE: begin
        if (press) begin
          start_d = 1'b1;
          score_d = 10'd0;
          rgb_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = S_RUNNING;
        end
      end

      S_RUNNING: begin
        // Collision takes precedence over a simultaneous score tick.
        if (i_collision && !coll_masked) begin
          state_d = S_DYING;
          frame_d = 6'd0;
        end else if (i_tick_20hz && (score_q != SCORE_MAX)) begin
          score_d = score_inc;
          if (is_hundred(score_inc)) begin
            rgb_d = ~rgb_q;
          end
        end
      end

      S_DYING: begin
        if (i_tick_60hz) begin
          frame_d = frame_inc;
          if (frame_inc[2:0] == 3'd0) begin
            inv_d = ~inv_q;
          end
          if (frame_inc == DYING_TICKS) begin
            state_d = S_GAME_OVER;
            frame_d = 6'd0;
            inv_d   = 1'b0;
          end
        end
      end

      S_GAME_OVER: begin
        // Counter saturates at the lockout length; reaching it unlocks restart.
        if (frame_q >= LOCKOUT_TICKS) begin
          if (press) begin
            start_d = 1'b1;
            score_d = 10'd0;
            rgb_d   = 1'b0;
            inv_d   = 1'b0;
            state_d = S_RUNNING;
          end
        end else if (i_tick_60hz) begin
          frame_d = frame_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      score_q <= 10'd0;
      rgb_q   <= 1'b0;
      inv_q   <= 1'b0;
      start_q <= 1'b0;
      frame_q <= 6'd0;
      btn_q   <= 1'b0;
      mask_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      rgb_q   <= rgb_d;
      inv_q   <= inv_d;
      start_q <= start_d;
      frame_q <= frame_d;
      btn_q   <= i_button;
      mask_q  <= start_q;
    end
  end

  always_comb begin
    if (score_q < 10'd250)      o_speed = 2'd0;
    else if (score_q < 10'd500) o_speed = 2'd1;
    else if (score_q < 10'd750) o_speed = 2'd2;
    else                        o_speed = 2'd3;
  end

  assign o_game_start_pulse = start_q;
  assign o_state            = state_q;
  assign o_score            = score_q;
  assign o_rgb_scheme       = rgb_q;
  assign o_invert           = inv_q;

endmodule
